bird_physics: RTL and testbench

//   Parametrised vertical-motion engine for the player bird: signed velocity, per-tick gravity,

---
 rtl/bird_physics.sv | 149 ++++++++++++++
 tb/tb_bird_physics.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_physics.sv
// rtl/bird_physics.sv - vertical motion engine for the player bird
module bird_physics #(
  parameter int Y_WIDTH      = 8,
  parameter int V_WIDTH      = 6,
  parameter int Y_INIT       = 60,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 119,
  parameter int GRAVITY      = 1,
  parameter int V_MAX        = 7,
  parameter int FLAP_IMPULSE = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      tick_i,
  input  logic                      start_i,
  input  logic                      flap_i,
  input  logic                      hit_i,
  output logic [Y_WIDTH-1:0]        y_pos_o,
  output logic signed [V_WIDTH-1:0] velocity_o,
  output logic                      alive_o,
  output logic                      crashed_o,
  output logic                      y_valid_o
);

  // Wide widths so velocity + gravity and row + velocity never wrap.
  localparam int VW = V_WIDTH + 1;
  localparam int YW = Y_WIDTH + 2;

  localparam logic signed [VW-1:0] VMAX_W = VW'(V_MAX);
  localparam logic signed [VW-1:0] GRAV_W = VW'(GRAVITY);
  localparam logic signed [YW-1:0] YMIN_W = YW'(Y_MIN);
  localparam logic signed [YW-1:0] YMAX_W = YW'(Y_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [Y_WIDTH-1:0]          y_pos_q, y_pos_d;
  logic signed [V_WIDTH-1:0]   vel_q, vel_d;
  logic                        flap_q;
  logic                        flap_pend_q, flap_pend_d;
  logic                        upd_q, upd_d;
  logic                        y_valid_q;
  logic                        alive_q, alive_d;
  logic                        crashed_q, crashed_d;

  logic                        flap_rise;
  logic signed [VW-1:0]        v_ext;
  logic signed [VW-1:0]        v_inc;
  logic signed [V_WIDTH-1:0]   v_tick;
  logic signed [YW-1:0]        y_sum;

  assign flap_rise = flap_i & ~flap_q;

  // Candidate velocity and row for a physics tick: impulse or gravity with terminal clamp.
  always_comb begin
    v_ext = {vel_q[V_WIDTH-1], vel_q};
    v_inc = v_ext + GRAV_W;
    if (flap_pend_q) begin
      v_tick = V_WIDTH'(-FLAP_IMPULSE);
    end else if (v_inc > VMAX_W) begin
      v_tick = V_WIDTH'(V_MAX);
    end else begin
      v_tick = v_inc[V_WIDTH-1:0];
    end
    y_sum = $signed({2'b00, y_pos_q}) + YW'(v_tick);
  end

  // Life-cycle FSM and motion update; hit beats a same-cycle tick, and a
  // flap rise arriving with the consuming tick stays pending for the next one.
  always_comb begin
    state_d     = state_q;
    y_pos_d     = y_pos_q;
    vel_d       = vel_q;
    flap_pend_d = flap_pend_q | flap_rise;
    upd_d       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DEAD: begin
        if (start_i) begin
          state_d     = ST_FLY;
          y_pos_d     = Y_WIDTH'(Y_INIT);
          vel_d       = '0;
          flap_pend_d = 1'b0;
        end
      end
      ST_FLY: begin
        if (hit_i) begin
          state_d = ST_DEAD;
        end else if (tick_i) begin
          upd_d       = 1'b1;
          flap_pend_d = flap_rise;
          if (y_sum <= YMIN_W) begin
            y_pos_d = Y_WIDTH'(Y_MIN);
            vel_d   = '0;
          end else if (y_sum >= YMAX_W) begin
            y_pos_d = Y_WIDTH'(Y_MAX);
            vel_d   = '0;
            state_d = ST_DEAD;
          end else begin
            y_pos_d = y_sum[Y_WIDTH-1:0];
            vel_d   = v_tick;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    alive_d   = (state_d == ST_FLY);
    crashed_d = (state_d == ST_DEAD);
  end

  // State, motion and status registers; y_valid trails the motion update by one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      y_pos_q     <= Y_WIDTH'(Y_INIT);
      vel_q       <= '0;
      flap_q      <= 1'b0;
      flap_pend_q <= 1'b0;
      upd_q       <= 1'b0;
      y_valid_q   <= 1'b0;
      alive_q     <= 1'b0;
      crashed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_pos_q     <= y_pos_d;
      vel_q       <= vel_d;
      flap_q      <= flap_i;
      flap_pend_q <= flap_pend_d;
      upd_q       <= upd_d;
      y_valid_q   <= upd_q;
      alive_q     <= alive_d;
      crashed_q   <= crashed_d;
    end
  end

  assign y_pos_o    = y_pos_q;
  assign velocity_o = vel_q;
  assign alive_o    = alive_q;
  assign crashed_o  = crashed_q;
  assign y_valid_o  = y_valid_q;

endmodule

// File: tb/tb_bird_physics.sv
// tb/tb_bird_physics.sv - self-checking bench for bird_physics
module tb_bird_physics;

  logic              clk;
  logic              reset;
  logic              tick;
  logic              start;
  logic              flap;
  logic              hit;
  logic [7:0]        y_pos;
  logic signed [5:0] velocity;
  logic              alive;
  logic              crashed;
  logic              y_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle 1=fly 2=dead, plain integer physics
  int m_mode, m_y, m_v, m_pend, m_prev_flap, m_upd, m_valid;

  bird_physics dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .tick_i     (tick),
    .start_i    (start),
    .flap_i     (flap),
    .hit_i      (hit),
    .y_pos_o    (y_pos),
    .velocity_o (velocity),
    .alive_o    (alive),
    .crashed_o  (crashed),
    .y_valid_o  (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_y = 60; m_v = 0; m_pend = 0;
    m_prev_flap = 0; m_upd = 0; m_valid = 0;
  endtask

  task automatic model_clock(input int t, input int s, input int f, input int h);
    int rise, upd, vn, yn;
    rise = (f != 0 && m_prev_flap == 0) ? 1 : 0;
    upd = 0;
    if (m_mode == 1) begin
      if (h != 0) begin
        m_mode = 2;
        m_pend = m_pend | rise;
      end else if (t != 0) begin
        upd = 1;
        if (m_pend != 0) vn = -4;
        else vn = (m_v + 1 > 7) ? 7 : m_v + 1;
        yn = m_y + vn;
        if (yn <= 0) begin m_y = 0; m_v = 0; end
        else if (yn >= 119) begin m_y = 119; m_v = 0; m_mode = 2; end
        else begin m_y = yn; m_v = vn; end
        m_pend = rise;
      end else begin
        m_pend = m_pend | rise;
      end
    end else begin
      if (s != 0) begin
        m_mode = 1; m_y = 60; m_v = 0; m_pend = 0;
      end else begin
        m_pend = m_pend | rise;
      end
    end
    m_valid = m_upd;
    m_upd = upd;
    m_prev_flap = f;
  endtask

  // One clock with the given inputs; returns #1 after the edge.
  task automatic step(input logic t, input logic s, input logic f, input logic h);
    tick = t; start = s; flap = f; hit = h;
    @(posedge clk);
    model_clock(int'(t), int'(s), int'(f), int'(h));
    #1;
  endtask

  task automatic do_reset();
    tick = 0; start = 0; flap = 0; hit = 0;
    reset = 1'b1;
    #3;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick = 0; start = 0; flap = 0; hit = 0;
    reset = 1'b1;
    #3;
    checks++;
    if ({y_pos, velocity, alive, crashed, y_valid} !== {8'd60, 6'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got y=%0d v=%0d a=%0d c=%0d yv=%0d exp y=60 v=0 a=0 c=0 yv=0",
               y_pos, velocity, alive, crashed, y_valid);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle_ticks();
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      if (y_valid === 1'b1) pulses++;
      step(0, 0, 0, 0);
      if (y_valid === 1'b1) pulses++;
    end
    checks++;
    if ({y_pos, velocity, alive} !== {8'd60, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL idle_ticks got y=%0d v=%0d a=%0d exp y=60 v=0 a=0", y_pos, velocity, alive);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL idle_yvalid got %0d pulses exp 0", pulses);
    end
  endtask

  task automatic test_fall();
    int ev[3];
    int ey[3];
    int pulses = 0;
    ev = '{1, 2, 3};
    ey = '{61, 63, 66};
    step(0, 1, 0, 0);
    checks++;
    if ({alive, crashed, y_pos} !== {1'b1, 1'b0, 8'd60}) begin
      errors++;
      $display("FAIL start got a=%0d c=%0d y=%0d exp a=1 c=0 y=60", alive, crashed, y_pos);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if ($signed(velocity) !== ev[i] || int'(y_pos) !== ey[i] || y_valid !== 1'b0) begin
        errors++;
        $display("FAIL fall_tick%0d got v=%0d y=%0d yv=%0d exp v=%0d y=%0d yv=0",
                 i, velocity, y_pos, y_valid, ev[i], ey[i]);
      end
      step(0, 0, 0, 0);
      if (y_valid === 1'b1) pulses++;
      step(0, 0, 0, 0);
      if (y_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL fall_yvalid got %0d pulses exp 3", pulses);
    end
  endtask

  task automatic test_flap_held();
    int ev[5];
    int ey[5];
    ev = '{-4, -3, -2, -1, 0};
    ey = '{62, 59, 57, 56, 56};
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 0);
      checks++;
      if ($signed(velocity) !== ev[i] || int'(y_pos) !== ey[i]) begin
        errors++;
        $display("FAIL flap_held_tick%0d got v=%0d y=%0d exp v=%0d y=%0d",
                 i, velocity, y_pos, ev[i], ey[i]);
      end
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_free_fall();
    int maxv = 0;
    int nticks = 0;
    int pulses = 0;
    do_reset();
    step(0, 1, 0, 0);
    for (int i = 0; i < 40 && crashed !== 1'b1; i++) begin
      step(1, 0, 0, 0);
      nticks++;
      if ($signed(velocity) > maxv) maxv = $signed(velocity);
      step(0, 0, 0, 0);
    end
    checks++;
    if ({crashed, alive, y_pos, velocity} !== {1'b1, 1'b0, 8'd119, 6'd0}) begin
      errors++;
      $display("FAIL crash_state got c=%0d a=%0d y=%0d v=%0d exp c=1 a=0 y=119 v=0",
               crashed, alive, y_pos, velocity);
    end
    checks++;
    if (maxv != 7 || nticks != 12) begin
      errors++;
      $display("FAIL terminal_velocity got vmax=%0d ticks=%0d exp vmax=7 ticks=12", maxv, nticks);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, i[0], 0);
      if (y_valid === 1'b1) pulses++;
      step(0, 0, 0, 0);
      if (y_valid === 1'b1) pulses++;
    end
    checks++;
    if ({y_pos, velocity, crashed} !== {8'd119, 6'd0, 1'b1} || pulses != 0) begin
      errors++;
      $display("FAIL dead_frozen got y=%0d v=%0d c=%0d pulses=%0d exp y=119 v=0 c=1 pulses=0",
               y_pos, velocity, crashed, pulses);
    end
  endtask

  task automatic test_ceiling();
    step(0, 1, 0, 0);
    checks++;
    if ({y_pos, velocity, alive, crashed} !== {8'd60, 6'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_from_dead got y=%0d v=%0d a=%0d c=%0d exp y=60 v=0 a=1 c=0",
               y_pos, velocity, alive, crashed);
    end
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 1, 0);
      step(1, 0, 0, 0);
    end
    step(1, 0, 0, 0);
    checks++;
    if (y_pos !== 8'd5 || $signed(velocity) !== -3) begin
      errors++;
      $display("FAIL climb_to_5 got y=%0d v=%0d exp y=5 v=-3", y_pos, velocity);
    end
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    checks++;
    if (y_pos !== 8'd1 || $signed(velocity) !== -4) begin
      errors++;
      $display("FAIL flap_to_1 got y=%0d v=%0d exp y=1 v=-4", y_pos, velocity);
    end
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    checks++;
    if ({y_pos, velocity, alive} !== {8'd0, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL ceiling_clamp got y=%0d v=%0d a=%0d exp y=0 v=0 a=1", y_pos, velocity, alive);
    end
  endtask

  task automatic test_hit_tick();
    do_reset();
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (y_pos !== 8'd70) begin
      errors++;
      $display("FAIL reach_70 got y=%0d exp y=70", y_pos);
    end
    step(1, 0, 0, 1);
    checks++;
    if ({crashed, alive, y_pos, velocity} !== {1'b1, 1'b0, 8'd70, 6'd4}) begin
      errors++;
      $display("FAIL hit_wins got c=%0d a=%0d y=%0d v=%0d exp c=1 a=0 y=70 v=4",
               crashed, alive, y_pos, velocity);
    end
    step(0, 0, 0, 0);
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_no_yvalid got %0d exp 0", y_valid);
    end
  endtask

  task automatic test_reset_midflight();
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    tick = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({y_pos, velocity, alive, crashed} !== {8'd60, 6'd0, 2'b00}) begin
      errors++;
      $display("FAIL async_reset got y=%0d v=%0d a=%0d c=%0d exp y=60 v=0 a=0 c=0",
               y_pos, velocity, alive, crashed);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({y_pos, velocity, alive, y_valid} !== {8'd60, 6'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_over_tick got y=%0d v=%0d a=%0d yv=%0d exp y=60 v=0 a=0 yv=0",
               y_pos, velocity, alive, y_valid);
    end
    model_reset();
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic f;
    int bad = 0;
    f = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) f = ~f;
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0), f,
           ($urandom_range(0, 79) == 0));
      checks++;
      if ({y_pos, velocity, alive, crashed, y_valid} !==
          {8'(m_y), 6'(m_v), (m_mode == 1), (m_mode == 2), (m_valid != 0)}) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random_cycle%0d got y=%0d v=%0d a=%0d c=%0d yv=%0d exp y=%0d v=%0d a=%0d c=%0d yv=%0d",
                   i, y_pos, velocity, alive, crashed, y_valid,
                   m_y, m_v, (m_mode == 1), (m_mode == 2), m_valid);
      end
    end
    tick = 0; start = 0; flap = 0; hit = 0;
  endtask

  initial begin
    reset = 1'b1;
    tick = 0; start = 0; flap = 0; hit = 0;
    model_reset();
    test_reset();
    test_idle_ticks();
    test_fall();
    test_flap_held();
    test_free_fall();
    test_ceiling();
    test_hit_tick();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
